// File: rtl/delay_timer_pkg.sv
// Shared types and helpers for the multi-channel delay timer.
// Channel FSM encoding, default prescaler width, and load_val bus slicing.
package delay_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam int PRESCALER_DEF = 64;
    localparam int PRESC_W       = $clog2(PRESCALER_DEF);

    // Channel ch's delay occupies load_val[ch_lsb(ch, cnt_w) +: cnt_w].
    function automatic int ch_lsb(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/delay_timer_ch.sv
// One timer channel: FSM, down-counter, reload register, done pulse and sticky flag.
// Latency: done_pulse one cycle after the expiring tick; a zero-delay start pulses on the next cycle.
// Backpressure: none; strobes are accepted every cycle with priority stop > start > expiry.
module delay_timer_ch
    import delay_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             clr_done,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             done_pulse,
    output logic             done_flag
);

    ch_state_t        state_q;
    ch_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload_q;
    logic             mode_q;
    logic             exp_q;
    logic             done_pulse_q;
    logic             done_flag_q;
    logic             pulse_set;
    logic             flag_d;
    logic             load_zero;
    logic             last_tick;

    assign load_zero = (load_val == '0);
    assign last_tick = (state_q == RUN) && tick && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A one-shot channel stays in RUN through the cycle its expiry is staged in exp_q.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = load_zero ? IDLE : RUN;
        end else if (exp_q && !mode_q) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        busy      = (state_q == RUN);
        pulse_set = 1'b0;
        if (!stop) begin
            pulse_set = start ? load_zero : exp_q;
        end
        flag_d = done_flag_q;
        if (clr_done || (start && !stop)) begin
            flag_d = 1'b0;
        end
        if (pulse_set) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q        <= '0;
            reload_q     <= '0;
            mode_q       <= 1'b0;
            exp_q        <= 1'b0;
            done_pulse_q <= 1'b0;
            done_flag_q  <= 1'b0;
        end else begin
            exp_q        <= last_tick && !stop && !start;
            done_pulse_q <= pulse_set;
            done_flag_q  <= flag_d;
            if (stop) begin
                cnt_q <= '0;
            end else if (start) begin
                cnt_q    <= load_val;
                reload_q <= load_val;
                mode_q   <= periodic;
            end else if ((state_q == RUN) && tick) begin
                // Compare before decrement so the counter never wraps below zero.
                if (cnt_q == CNT_W'(1)) begin
                    cnt_q <= mode_q ? reload_q : '0;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign done_pulse = done_pulse_q;
    assign done_flag  = done_flag_q;

endmodule

// File: rtl/delay_timer_mc.sv
// Multi-channel delay timer: shared prescaler feeding N_CH independent channels; DELAY_TIMER_MC_IRQ_EN adds irq/irq_mask.
// Latency: load_val*PRESCALER+1 cycles start-to-pulse from all-idle; irq one cycle after a masked flag sets.
// Backpressure: none; start/stop/clr_done are single-cycle strobes accepted every cycle.
module delay_timer_mc
    import delay_timer_pkg::*;
#(
    parameter int FREQ_MHZ  = 12,
    parameter int PRESCALER = PRESCALER_DEF,
    parameter int N_CH      = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH-1:0]         periodic,
    input  logic [N_CH*CNT_W-1:0]   load_val,
    input  logic [N_CH-1:0]         clr_done,
`ifdef DELAY_TIMER_MC_IRQ_EN
    input  logic [N_CH-1:0]         irq_mask,
    output logic                    irq,
`endif
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done_pulse,
    output logic [N_CH-1:0]         done_flag
);

    // FREQ_MHZ is documentary; only positive values describe a real build.
    localparam int PS_W = (FREQ_MHZ > 0) ? $clog2(PRESCALER) : 1;

    logic [PS_W-1:0] presc_q;
    logic            any_busy;
    logic            presc_last;
    logic            tick;

    assign any_busy   = |busy;
    assign presc_last = (presc_q == PS_W'(PRESCALER - 1));
    assign tick       = any_busy && presc_last;

    // Phase is shared by all channels and parks at zero whenever nothing is counting.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            presc_q <= '0;
        end else if (!any_busy || presc_last) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PS_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        delay_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_l      (rst_l),
            .tick       (tick),
            .start      (start[i]),
            .stop       (stop[i]),
            .clr_done   (clr_done[i]),
            .periodic   (periodic[i]),
            .load_val   (load_val[ch_lsb(i, CNT_W) +: CNT_W]),
            .busy       (busy[i]),
            .done_pulse (done_pulse[i]),
            .done_flag  (done_flag[i])
        );
    end

`ifdef DELAY_TIMER_MC_IRQ_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            irq <= 1'b0;
        end else begin
            irq <= |(done_flag & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_delay_timer_mc.sv
// Self-checking bench for delay_timer_mc: directed scenarios plus randomized traffic against a tick-level model.
module tb_delay_timer_mc;

    localparam int P = 4;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk      = 1'b0;
    logic           rst_l    = 1'b0;
    logic [N-1:0]   start    = '0;
    logic [N-1:0]   stop     = '0;
    logic [N-1:0]   periodic = '0;
    logic [N-1:0]   clr_done = '0;
    logic [N*W-1:0] load_val = '0;
    logic [N-1:0]   busy;
    logic [N-1:0]   done_pulse;
    logic [N-1:0]   done_flag;
`ifdef DELAY_TIMER_MC_IRQ_EN
    logic [N-1:0]   irq_mask = '0;
    logic           irq;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: ticks remaining per channel and the shared prescaler phase.
    int           m_phase = 0;
    bit           m_run [N];
    int           m_left [N];
    int           m_reload [N];
    bit           m_per [N];
    bit           m_pend [N];
    logic [N-1:0] m_busy  = '0;
    logic [N-1:0] m_pulse = '0;
    logic [N-1:0] m_flag  = '0;
    logic         m_irq   = 1'b0;

    always #5 clk = ~clk;

    delay_timer_mc #(
        .FREQ_MHZ  (12),
        .PRESCALER (P),
        .N_CH      (N),
        .CNT_W     (W)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .load_val   (load_val),
        .clr_done   (clr_done),
`ifdef DELAY_TIMER_MC_IRQ_EN
        .irq_mask   (irq_mask),
        .irq        (irq),
`endif
        .busy       (busy),
        .done_pulse (done_pulse),
        .done_flag  (done_flag)
    );

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 1'b0; m_left[i] = 0; m_reload[i] = 0; m_per[i] = 1'b0; m_pend[i] = 1'b0;
        end
        m_busy = '0; m_pulse = '0; m_flag = '0; m_irq = 1'b0;
    endtask

    task automatic model_step();
        bit           any = 1'b0;
        bit           tk;
        int           lv;
        logic [N-1:0] np;
        logic [N-1:0] nf;
        for (int i = 0; i < N; i++) any |= m_run[i];
        tk = any && (m_phase == P - 1);
`ifdef DELAY_TIMER_MC_IRQ_EN
        m_irq = |(m_flag & irq_mask);
`endif
        m_phase = any ? (m_phase + 1) % P : 0;
        np = '0;
        nf = m_flag;
        for (int i = 0; i < N; i++) begin
            lv = int'(load_val[i*W +: W]);
            if (clr_done[i] || (start[i] && !stop[i])) nf[i] = 1'b0;
            if (stop[i]) begin
                m_run[i] = 1'b0; m_pend[i] = 1'b0;
            end else if (start[i]) begin
                m_pend[i] = 1'b0;
                if (lv == 0) begin
                    m_run[i] = 1'b0; np[i] = 1'b1;
                end else begin
                    m_run[i] = 1'b1; m_left[i] = lv; m_reload[i] = lv; m_per[i] = periodic[i];
                end
            end else if (m_pend[i]) begin
                m_pend[i] = 1'b0; np[i] = 1'b1;
                if (!m_per[i]) m_run[i] = 1'b0;
            end else if (m_run[i] && tk) begin
                if (m_left[i] == 1) begin
                    m_pend[i] = 1'b1;
                    m_left[i] = m_per[i] ? m_reload[i] : 0;
                end else begin
                    m_left[i] = m_left[i] - 1;
                end
            end
            if (np[i]) nf[i] = 1'b1;
        end
        m_pulse = np;
        m_flag  = nf;
        for (int i = 0; i < N; i++) m_busy[i] = m_run[i];
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (!rst_l) model_reset();
        else model_step();
        #1;
        start    = '0;
        stop     = '0;
        clr_done = '0;
    endtask

    task automatic set_load(input int ch, input int v);
        load_val[ch*W +: W] = W'(v);
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) clk_step();
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got=%b exp=%b", busy, m_busy); end
        checks++; if (done_pulse !== '0) begin errors++; $display("FAIL reset_pulse got=%b exp=%b", done_pulse, m_pulse); end
        checks++; if (done_flag !== '0) begin errors++; $display("FAIL reset_flag got=%b exp=%b", done_flag, m_flag); end
        rst_l = 1'b1;
        clk_step();
    endtask

    task automatic test_oneshot();
        int lat;
        set_load(0, 3); periodic[0] = 1'b0; start[0] = 1'b1;
        clk_step();
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL oneshot_busy got=%b exp=1", busy[0]); end
        lat = 0;
        while (done_pulse[0] !== 1'b1 && lat < 40) begin clk_step(); lat++; end
        checks++; if (lat !== 13) begin errors++; $display("FAIL oneshot_latency got=%0d exp=13", lat); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL oneshot_busy_at_pulse got=%b exp=0", busy[0]); end
        repeat (3) clk_step();
        checks++; if (done_flag[0] !== 1'b1 || done_pulse[0] !== 1'b0) begin
            errors++; $display("FAIL oneshot_sticky flag=%b pulse=%b exp flag=1 pulse=0", done_flag[0], done_pulse[0]);
        end
        clr_done[0] = 1'b1;
        clk_step();
        checks++; if (done_flag[0] !== 1'b0) begin errors++; $display("FAIL oneshot_clr got=%b exp=0", done_flag[0]); end
    endtask

    task automatic test_periodic();
        int t;
        int last;
        int npulse;
        int exp_t;
        int late;
        bit busy_ok;
        set_load(1, 2); periodic[1] = 1'b1; start[1] = 1'b1;
        clk_step();
        t = 0; last = -1; npulse = 0; busy_ok = 1'b1;
        while (npulse < 5 && t < 100) begin
            if (busy[1] !== 1'b1) busy_ok = 1'b0;
            clk_step();
            t++;
            if (done_pulse[1] === 1'b1) begin
                exp_t = (last < 0) ? (2 * P + 1) : (last + 2 * P);
                checks++; if (t !== exp_t) begin errors++; $display("FAIL periodic_pulse_time got=%0d exp=%0d", t, exp_t); end
                last = t;
                npulse++;
            end
        end
        checks++; if (npulse !== 5) begin errors++; $display("FAIL periodic_count got=%0d exp=5", npulse); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL periodic_busy got=0 exp=1"); end
        stop[1] = 1'b1;
        clk_step();
        late = 0;
        repeat (20) begin
            if (done_pulse[1] !== 1'b0 || busy[1] !== 1'b0) late++;
            clk_step();
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL periodic_after_stop got=%0d exp=0", late); end
    endtask

    task automatic test_zero();
        set_load(2, 0); start[2] = 1'b1;
        clk_step();
        checks++; if (done_pulse[2] !== 1'b1) begin errors++; $display("FAIL zero_pulse got=%b exp=1", done_pulse[2]); end
        checks++; if (done_flag[2] !== 1'b1) begin errors++; $display("FAIL zero_flag got=%b exp=1", done_flag[2]); end
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy[2]); end
        clk_step();
        checks++; if (done_pulse[2] !== 1'b0 || busy[2] !== 1'b0) begin
            errors++; $display("FAIL zero_after pulse=%b busy=%b exp 0 0", done_pulse[2], busy[2]);
        end
        clr_done[2] = 1'b1;
        clk_step();
    endtask

    task automatic test_shared();
        int p0;
        int p3;
        p0 = -1; p3 = -1;
        set_load(0, 5); periodic[0] = 1'b0; start[0] = 1'b1;
        clk_step();
        for (int t = 1; t <= 30; t++) begin
            if (t == 6) begin set_load(3, 1); periodic[3] = 1'b0; start[3] = 1'b1; end
            clk_step();
            checks++; if (done_pulse !== m_pulse) begin errors++; $display("FAIL shared_model t=%0d got=%b exp=%b", t, done_pulse, m_pulse); end
            if (done_pulse[0] === 1'b1 && p0 < 0) p0 = t;
            if (done_pulse[3] === 1'b1 && p3 < 0) p3 = t - 6;
        end
        checks++; if (p0 !== 21) begin errors++; $display("FAIL shared_ch0_latency got=%0d exp=21", p0); end
        checks++; if (p3 < 2 || p3 > 5) begin errors++; $display("FAIL shared_ch3_latency got=%0d exp=2..5", p3); end
    endtask

    task automatic test_simultaneous();
        int bad;
        int lat;
        set_load(1, 3); periodic[1] = 1'b0; start[1] = 1'b1; stop[1] = 1'b1;
        clk_step();
        bad = 0;
        repeat (20) begin
            if (busy[1] !== 1'b0 || done_pulse[1] !== 1'b0) bad++;
            clk_step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL start_stop_idle got=%0d exp=0", bad); end
        // First count (2 ticks) would expire on edge 9; restart lands on its final tick edge 8.
        set_load(0, 2); periodic[0] = 1'b0; start[0] = 1'b1;
        clk_step();
        repeat (7) clk_step();
        set_load(0, 1); start[0] = 1'b1;
        clk_step();
        lat = 0;
        while (done_pulse[0] !== 1'b1 && lat < 20) begin clk_step(); lat++; end
        checks++; if (lat !== P + 1) begin errors++; $display("FAIL restart_latency got=%0d exp=%0d", lat, P + 1); end
        set_load(0, 1); start[0] = 1'b1;
        clk_step();
        repeat (4) clk_step();
        clr_done[0] = 1'b1;
        clk_step();
        checks++; if (done_pulse[0] !== 1'b1 || done_flag[0] !== 1'b1) begin
            errors++; $display("FAIL expiry_vs_clr pulse=%b flag=%b exp 1 1", done_pulse[0], done_flag[0]);
        end
        set_load(2, 0); start[2] = 1'b1; clr_done[2] = 1'b1;
        clk_step();
        checks++; if (done_flag[2] !== 1'b1) begin errors++; $display("FAIL set_vs_clear got=%b exp=1", done_flag[2]); end
    endtask

    task automatic test_reset_mid();
        int bad;
        set_load(0, 5); periodic[0] = 1'b0; start[0] = 1'b1;
        set_load(1, 3); periodic[1] = 1'b1; start[1] = 1'b1;
        clk_step();
        repeat (7) clk_step();
        #2 rst_l = 1'b0;
        #1;
        checks++; if ({busy, done_pulse, done_flag} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs busy=%b pulse=%b flag=%b exp all 0", busy, done_pulse, done_flag);
        end
        clk_step();
        clk_step();
        rst_l = 1'b1;
        bad = 0;
        repeat (40) begin
            clk_step();
            if (done_pulse !== '0 || busy !== '0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_mid_after got=%0d exp=0", bad); end
`ifdef DELAY_TIMER_MC_IRQ_EN
        irq_mask = 4'b0100;
        set_load(2, 0); start[2] = 1'b1;
        clk_step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got=%b exp=0", irq); end
        clk_step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got=%b exp=1", irq); end
        irq_mask = 4'b0000;
        clk_step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", irq); end
        clr_done[2] = 1'b1;
        clk_step();
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) begin
                    start[i] = 1'b1;
                    set_load(i, int'($urandom_range(0, 5)));
                    periodic[i] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 39) == 0) stop[i] = 1'b1;
                if ($urandom_range(0, 15) == 0) clr_done[i] = 1'b1;
            end
`ifdef DELAY_TIMER_MC_IRQ_EN
            if ($urandom_range(0, 31) == 0) irq_mask = N'($urandom_range(0, 15));
`endif
            clk_step();
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, m_busy); end
            checks++; if (done_pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse c=%0d got=%b exp=%b", c, done_pulse, m_pulse); end
            checks++; if (done_flag !== m_flag) begin errors++; $display("FAIL rand_flag c=%0d got=%b exp=%b", c, done_flag, m_flag); end
`ifdef DELAY_TIMER_MC_IRQ_EN
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq c=%0d got=%b exp=%b", c, irq, m_irq); end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_zero();
        test_shared();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
